muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_step.sv | 57 +++++
 rtl/muldiv_seq.sv | 176 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the sequential multiply/divide unit.
//   op_e    : operation encoding presented on the op port
//   state_e : controller FSM state encoding
//   op_is_div / op_is_signed : decode helpers used by the controller
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Bit 1 of the encoding selects divide, bit 0 selects signed.
    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the shift-add multiplier / restoring divider.
//   i_div : 1 = restoring divide step, 0 = shift-add multiply step
//   i_hi  : partial product upper half, or partial remainder
//   i_lo  : multiplier bits still to consume, or dividend bits / quotient
//   i_m   : multiplicand magnitude, or divisor magnitude
//   o_hi  : next upper half / remainder
//   o_lo  : next lower half / quotient
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    // Shared WIDTH+1 bit adder/subtractor. For multiply bit WIDTH is the
    // carry that shifts back into the product; for divide it is the borrow.
    logic [WIDTH:0] w_addsub;
    logic [WIDTH:0] w_mul_sel;

    always_comb begin
        if (i_div) begin
            // Partial remainder shifted left by one with the next dividend bit.
            // Since the remainder is always below the divisor, bit WIDTH of
            // the difference is set exactly when the subtraction underflows.
            w_addsub = {i_hi, i_lo[WIDTH-1]} - {1'b0, i_m};
        end else begin
            w_addsub = {1'b0, i_hi} + {1'b0, i_m};
        end
    end

    assign w_mul_sel = i_lo[0] ? w_addsub : {1'b0, i_hi};

    always_comb begin
        if (i_div) begin
            if (!w_addsub[WIDTH]) begin
                o_hi = w_addsub[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                // Restore: keep the shifted remainder, quotient bit 0.
                o_hi = {i_hi[WIDTH-2:0], i_lo[WIDTH-1]};
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Product {hi,lo} shifts right; consumed multiplier bit drops out.
            o_hi = w_mul_sel[WIDTH:1];
            o_lo = {w_mul_sel[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Sequential 32-bit (WIDTH) multiply/divide unit, MIPS HI/LO style.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   start : request an operation (accepted in IDLE or DONE)
//   op    : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b  : multiplicand/dividend, multiplier/divisor
//   busy  : high in PREP, RUN, FIX
//   done  : one-cycle pulse in DONE, hi/lo carry the new result
//   hi    : product upper half or remainder
//   lo    : product lower half or quotient
// Latency is WIDTH+3 cycles: PREP, WIDTH iterating RUN cycles, one RUN cycle
// that detects the terminal count, FIX, then DONE.
// -----------------------------------------------------------------------------
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi_w;
    logic [WIDTH-1:0] r_lo_w;
    logic [WIDTH-1:0] r_cnt;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_div;
    logic             w_is_signed;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_is_div    = op_is_div(r_op);
    assign w_is_signed = op_is_signed(r_op);

    // Magnitudes; the most negative value maps onto itself, which is the
    // correct unsigned magnitude and makes 0x80000000 / -1 fall out naturally.
    assign w_a_mag = (w_is_signed && r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
    assign w_b_mag = (w_is_signed && r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;

    assign w_prod_neg = ~{r_hi_w, r_lo_w} + 1'b1;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div (w_is_div),
        .i_hi  (r_hi_w),
        .i_lo  (r_lo_w),
        .i_m   (r_m),
        .o_hi  (w_step_hi),
        .o_lo  (w_step_lo)
    );

    // Sign correction and divide-by-zero override, committed on FIX -> DONE.
    always_comb begin
        w_fix_hi = r_hi_w;
        w_fix_lo = r_lo_w;
        if (!w_is_div) begin
            if (r_neg_res) begin
                {w_fix_hi, w_fix_lo} = w_prod_neg;
            end
        end else if (r_dbz) begin
            w_fix_hi = r_a;
            w_fix_lo = '1;
        end else begin
            if (r_neg_res) begin
                w_fix_lo = ~r_lo_w + 1'b1;
            end
            if (r_neg_rem) begin
                w_fix_hi = ~r_hi_w + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op      <= OP_MULTU;
            r_a       <= '0;
            r_b       <= '0;
            r_m       <= '0;
            r_hi_w    <= '0;
            r_lo_w    <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= op_e'(op);
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= PREP;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                PREP: begin
                    r_cnt     <= '0;
                    r_hi_w    <= '0;
                    // Multiply iterates over b, dividing shifts a out of lo.
                    r_m       <= w_is_div ? w_b_mag : w_a_mag;
                    r_lo_w    <= w_is_div ? w_a_mag : w_b_mag;
                    r_neg_res <= w_is_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_rem <= w_is_signed & w_is_div & r_a[WIDTH-1];
                    r_dbz     <= w_is_div & (r_b == '0);
                    r_state   <= RUN;
                end
                RUN: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FIX;
                    end else begin
                        r_hi_w <= w_step_hi;
                        r_lo_w <= w_step_lo;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed table of operations with hand-computed HI/LO and latency, plus
// hand-written sequences for start-while-busy, reset mid-run, reset/start
// priority and back-to-back operation.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

    localparam int W       = 32;
    localparam int LAT     = W + 3;
    localparam int TIMEOUT = 100;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs [12];

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Wait for done after an accepting edge; returns cycles counted, -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    // Drive one operation starting at the next falling edge, scramble the
    // inputs after acceptance, and wait for the result.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int n_done;
        logic [W-1:0] cap_hi;
        logic [W-1:0] cap_lo;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{2'b10, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[5]  = '{2'b11, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
        vecs[6]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[7]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{2'b10, 32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999};
        vecs[10] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[11] = '{2'b10, 32'd3,         32'd9,         32'h0000_0003, 32'h0000_0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        // Table-driven operations
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            $display("vec %0d op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, lat);
            check($sformatf("vec%0d latency", i), lat, LAT);
            check($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
            check($sformatf("vec%0d busy at done", i), {31'b0, busy}, 32'd0);
        end

        // Start pulsed while busy is ignored: exactly one done
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after accept", {31'b0, busy}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; cap_hi = '0; cap_lo = '0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                cap_hi = hi; cap_lo = lo;
            end
        end
        check("ignored start done count", n_done, 32'd1);
        check("ignored start hi", cap_hi, 32'h0000_0064);
        check("ignored start lo", cap_lo, 32'hFFFF_FFFF);

        // Reset during RUN iteration 10
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrun reset busy", {31'b0, busy}, 32'd0);
        check("midrun reset done", {31'b0, done}, 32'd0);
        check("midrun reset hi", hi, 32'd0);
        check("midrun reset lo", lo, 32'd0);
        n_done = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("no done after reset", n_done, 32'd0);
        run_op(2'b00, 32'd5, 32'd6, lat);
        check("fresh 5*6 latency", lat, LAT);
        check("fresh 5*6 lo", lo, 32'd30);
        check("fresh 5*6 hi", hi, 32'd0);

        // Reset has priority over start in the same cycle
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("reset over start busy", {31'b0, busy}, 32'd0);

        // Back-to-back: DIVU 9/4 then MULTU 3*3 started in the DONE cycle
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check("b2b first latency", lat, LAT);
        check("b2b first lo", lo, 32'd2);
        check("b2b first hi", hi, 32'd1);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b second busy", {31'b0, busy}, 32'd1);
        wait_done(lat);
        check("b2b second latency", lat, LAT);
        check("b2b second lo", lo, 32'd9);
        check("b2b second hi", hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
